// File: rtl/cmd_frame_builder.sv
// cmd_frame_builder: builds the 48-bit SD command frame with a bit-serial CRC7,
// hands it to the CMD-line serializer and reports completion or send timeout.
module cmd_frame_builder #(
    parameter int FRAME_W      = 48,
    parameter int SEND_TIMEOUT = 64
) (
    input  logic               sd_clock,
    input  logic               reset,
    input  logic               new_command,
    input  logic [5:0]         cmd_index,
    input  logic [31:0]        cmd_argument,
    output logic [FRAME_W-1:0] frame,
    output logic               ser_enable,
    output logic               ser_load_send,
    input  logic               ser_complete,
    output logic               busy,
    output logic               cmd_sent,
    output logic               cmd_timeout
);
    localparam int TW = $clog2(SEND_TIMEOUT);

    typedef enum logic [2:0] {IDLE, CRC, LOAD, SEND, DONE, ABORT} state_t;

    state_t             state_q, state_d;
    logic [39:0]        hdr_q, hdr_d;
    logic [6:0]         crc_q, crc_d, crc_nxt;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               ser_enable_q, ser_enable_d;
    logic               ser_load_send_q, ser_load_send_d;
    logic               busy_q, busy_d;
    logic               cmd_sent_q, cmd_sent_d;
    logic               cmd_timeout_q, cmd_timeout_d;
    logic               fb;

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        crc_d     = crc_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        frame_d   = frame_q;
        fb        = hdr_q[6'd39 - bit_cnt_q] ^ crc_q[6];
        crc_nxt   = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
        case (state_q)
            IDLE: begin
                if (new_command) begin
                    hdr_d     = {2'b01, cmd_index, cmd_argument};
                    crc_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = CRC;
                end
            end
            CRC: begin
                crc_d     = crc_nxt;
                bit_cnt_d = bit_cnt_q + 6'd1;
                // Last header bit: the frame takes the CRC including this bit.
                if (bit_cnt_q == 6'd39) begin
                    frame_d = {hdr_q, crc_nxt, 1'b1};
                    state_d = LOAD;
                end
            end
            LOAD: begin
                timer_d = '0;
                state_d = SEND;
            end
            SEND: begin
                if (ser_complete)
                    state_d = DONE;
                else if (timer_q == TW'(SEND_TIMEOUT - 1))
                    state_d = ABORT;
                else
                    timer_d = timer_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ser_enable_d    = state_d == LOAD;
        ser_load_send_d = state_d == SEND;
        busy_d          = state_d != IDLE;
        cmd_sent_d      = state_d == DONE;
        cmd_timeout_d   = state_d == ABORT;
    end

    always_ff @(posedge sd_clock) begin
        if (!reset) begin
            state_q         <= IDLE;
            hdr_q           <= '0;
            crc_q           <= '0;
            bit_cnt_q       <= '0;
            timer_q         <= '0;
            frame_q         <= '0;
            ser_enable_q    <= 1'b0;
            ser_load_send_q <= 1'b0;
            busy_q          <= 1'b0;
            cmd_sent_q      <= 1'b0;
            cmd_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            hdr_q           <= hdr_d;
            crc_q           <= crc_d;
            bit_cnt_q       <= bit_cnt_d;
            timer_q         <= timer_d;
            frame_q         <= frame_d;
            ser_enable_q    <= ser_enable_d;
            ser_load_send_q <= ser_load_send_d;
            busy_q          <= busy_d;
            cmd_sent_q      <= cmd_sent_d;
            cmd_timeout_q   <= cmd_timeout_d;
        end
    end

    assign frame         = frame_q;
    assign ser_enable    = ser_enable_q;
    assign ser_load_send = ser_load_send_q;
    assign busy          = busy_q;
    assign cmd_sent      = cmd_sent_q;
    assign cmd_timeout   = cmd_timeout_q;
endmodule

// File: tb/tb_cmd_frame_builder.sv
// tb_cmd_frame_builder: scoreboard bench for cmd_frame_builder with a simple serializer model.
module tb_cmd_frame_builder;
    logic        sd_clock = 1'b0;
    logic        reset = 1'b0;
    logic        new_command = 1'b0;
    logic        ser_complete = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_argument = '0;
    logic [47:0] frame;
    logic        ser_enable, ser_load_send, busy, cmd_sent, cmd_timeout;
    int          checks = 0;
    int          failures = 0;
    logic [47:0] exp_q[$];

    cmd_frame_builder dut (
        .sd_clock     (sd_clock),
        .reset        (reset),
        .new_command  (new_command),
        .cmd_index    (cmd_index),
        .cmd_argument (cmd_argument),
        .frame        (frame),
        .ser_enable   (ser_enable),
        .ser_load_send(ser_load_send),
        .ser_complete (ser_complete),
        .busy         (busy),
        .cmd_sent     (cmd_sent),
        .cmd_timeout  (cmd_timeout)
    );

    always #5 sd_clock = ~sd_clock;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       f;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            f = d[i] ^ c[6];
            c = {c[5:0], 1'b0};
            if (f) c = c ^ 7'h09;
        end
        return c;
    endfunction

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] e);
        @(negedge sd_clock);
        cmd_index    = idx;
        cmd_argument = arg;
        new_command  = 1'b1;
        exp_q.push_back(e);
        @(negedge sd_clock);
        new_command = 1'b0;
    endtask

    task automatic wait_load(output int cyc, output logic ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ser_enable) begin
                ok = 1'b1;
                break;
            end
            @(negedge sd_clock);
            cyc++;
        end
    endtask

    task automatic serve(input int delay, input int poke_at, input logic hold,
                         output int sends, output int n_sent, output int n_to, output int en,
                         output logic ls_evt, output logic ok);
        sends = 0; n_sent = 0; n_to = 0; en = 0; ls_evt = 1'b1; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sd_clock);
            ser_complete = 1'b0;
            new_command  = hold;
            if (ser_enable) en++;
            if (cmd_sent) begin n_sent++; ls_evt = ser_load_send; end
            if (cmd_timeout) begin n_to++; ls_evt = ser_load_send; end
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            if (ser_load_send) begin
                sends++;
                if (sends == delay) ser_complete = 1'b1;
                if (sends == poke_at) begin
                    new_command  = 1'b1;
                    cmd_index    = ~cmd_index;
                    cmd_argument = ~cmd_argument;
                end
            end
        end
        ser_complete = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge sd_clock);
        checks++;
        if ({frame, ser_enable, ser_load_send, busy, cmd_sent, cmd_timeout} !== 53'd0) begin
            failures++;
            $display("FAIL reset_outputs got frame=%h en=%b ls=%b busy=%b sent=%b to=%b exp all 0",
                     frame, ser_enable, ser_load_send, busy, cmd_sent, cmd_timeout);
        end
        reset = 1'b1;
        @(negedge sd_clock);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_cmd0();
        int cyc, sends, ns, nt, en;
        logic ok, ls;
        logic [47:0] e;
        issue(6'd0, 32'h0, 48'h40_00000000_95);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL cmd0_busy_e0 got=%b exp=1", busy); end
        checks++;
        if (ser_enable !== 1'b0) begin failures++; $display("FAIL cmd0_no_early_en got=%b exp=0", ser_enable); end
        wait_load(cyc, ok);
        checks++;
        if (!ok || cyc != 40) begin failures++; $display("FAIL cmd0_load_cycle got=%0d ok=%b exp=40", cyc, ok); end
        e = exp_q.pop_front();
        checks++;
        if (frame !== e) begin failures++; $display("FAIL cmd0_frame got=%h exp=%h", frame, e); end
        serve(1, 0, 1'b0, sends, ns, nt, en, ls, ok);
        checks++;
        if (en != 0) begin failures++; $display("FAIL cmd0_en_width extra cycles got=%0d exp=0", en); end
        checks++;
        if (!ok || ns != 1 || nt != 0) begin
            failures++; $display("FAIL cmd0_sent got sent=%0d to=%0d ok=%b exp 1/0/1", ns, nt, ok);
        end
    endtask

    task automatic test_cmd8();
        int cyc, sends, ns, nt, en;
        logic ok, ls;
        logic [47:0] e;
        issue(6'd8, 32'h000001AA, 48'h48_000001AA_87);
        wait_load(cyc, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || frame !== e) begin failures++; $display("FAIL cmd8_frame got=%h exp=%h", frame, e); end
        serve(5, 0, 1'b0, sends, ns, nt, en, ls, ok);
        checks++;
        if (!ok || ns != 1 || sends != 5) begin
            failures++; $display("FAIL cmd8_sent got sent=%0d sends=%0d exp 1/5", ns, sends);
        end
    endtask

    task automatic test_cmd17();
        int cyc, sends, ns, nt, en;
        logic ok, ls;
        logic [47:0] e;
        issue(6'd17, 32'h0, 48'h51_00000000_55);
        wait_load(cyc, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || frame !== e) begin failures++; $display("FAIL cmd17_frame got=%h exp=%h", frame, e); end
        serve(48, 0, 1'b0, sends, ns, nt, en, ls, ok);
        checks++;
        if (sends != 48) begin failures++; $display("FAIL cmd17_send_len got=%0d exp=48", sends); end
        checks++;
        if (!ok || ns != 1 || nt != 0) begin
            failures++; $display("FAIL cmd17_sent got sent=%0d to=%0d exp 1/0", ns, nt);
        end
        checks++;
        if (ls !== 1'b0) begin failures++; $display("FAIL cmd17_ls_drop got=%b exp=0", ls); end
    endtask

    task automatic test_timeout();
        int cyc, sends, ns, nt, en;
        logic ok, ls;
        logic [47:0] e;
        issue(6'd8, 32'h000001AA, 48'h48_000001AA_87);
        wait_load(cyc, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || frame !== e) begin failures++; $display("FAIL to_frame got=%h exp=%h", frame, e); end
        serve(0, 0, 1'b0, sends, ns, nt, en, ls, ok);
        checks++;
        if (sends != 64) begin failures++; $display("FAIL to_send_len got=%0d exp=64", sends); end
        checks++;
        if (!ok || nt != 1 || ns != 0) begin
            failures++; $display("FAIL to_pulse got to=%0d sent=%0d ok=%b exp 1/0/1", nt, ns, ok);
        end
        checks++;
        if (ls !== 1'b0) begin failures++; $display("FAIL to_ls_drop got=%b exp=0", ls); end
    endtask

    task automatic test_ignore();
        int cyc, sends, ns, nt, en;
        logic ok, ls;
        logic [47:0] e;
        issue(6'd8, 32'h000001AA, 48'h48_000001AA_87);
        wait_load(cyc, ok);
        e = exp_q.pop_front();
        serve(48, 10, 1'b0, sends, ns, nt, en, ls, ok);
        checks++;
        if (!ok || ns != 1) begin failures++; $display("FAIL ign_one_sent got=%0d exp=1", ns); end
        @(negedge sd_clock);
        checks++;
        if (frame !== e || busy !== 1'b0) begin
            failures++; $display("FAIL ign_frame_hold got frame=%h busy=%b exp=%h busy=0", frame, busy, e);
        end
    endtask

    task automatic test_reset_crc();
        int cyc, sends, ns, nt, en;
        logic ok, ls;
        logic [47:0] e;
        issue(6'd17, 32'h0, 48'h51_00000000_55);
        void'(exp_q.pop_back());
        repeat (20) @(negedge sd_clock);
        reset = 1'b0;
        @(negedge sd_clock);
        checks++;
        if ({frame, ser_enable, ser_load_send, busy, cmd_sent, cmd_timeout} !== 53'd0) begin
            failures++; $display("FAIL rst_crc_outputs got frame=%h busy=%b exp all 0", frame, busy);
        end
        reset = 1'b1;
        @(negedge sd_clock);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_crc_idle busy got=%b exp=0", busy); end
        issue(6'd0, 32'h0, 48'h40_00000000_95);
        wait_load(cyc, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cyc != 40 || frame !== e) begin
            failures++; $display("FAIL rst_crc_cmd0 got=%h cyc=%0d exp=%h cyc=40", frame, cyc, e);
        end
        serve(3, 0, 1'b0, sends, ns, nt, en, ls, ok);
    endtask

    task automatic test_reset_send();
        int cyc, sends, ns, nt, en;
        logic ok, ls;
        logic [47:0] e;
        issue(6'd8, 32'h000001AA, 48'h48_000001AA_87);
        wait_load(cyc, ok);
        void'(exp_q.pop_front());
        repeat (10) @(negedge sd_clock);
        checks++;
        if (ser_load_send !== 1'b1) begin failures++; $display("FAIL rst_send_pre ls got=%b exp=1", ser_load_send); end
        reset = 1'b0;
        @(negedge sd_clock);
        checks++;
        if ({frame, ser_enable, ser_load_send, busy, cmd_sent, cmd_timeout} !== 53'd0) begin
            failures++; $display("FAIL rst_send_outputs got frame=%h ls=%b busy=%b exp all 0", frame, ser_load_send, busy);
        end
        reset = 1'b1;
        @(negedge sd_clock);
        issue(6'd0, 32'h0, 48'h40_00000000_95);
        wait_load(cyc, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || frame !== e) begin failures++; $display("FAIL rst_send_cmd0 got=%h exp=%h", frame, e); end
        serve(2, 0, 1'b0, sends, ns, nt, en, ls, ok);
        checks++;
        if (!ok || ns != 1) begin failures++; $display("FAIL rst_send_done got=%0d exp=1", ns); end
    endtask

    task automatic test_back_to_back();
        int cyc, sends, ns, nt, en;
        logic ok, ls;
        logic [47:0] e;
        logic [39:0] h;
        @(negedge sd_clock);
        cmd_index    = 6'd8;
        cmd_argument = 32'h000001AA;
        new_command  = 1'b1;
        exp_q.push_back(48'h48_000001AA_87);
        @(negedge sd_clock);
        wait_load(cyc, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || frame !== e) begin failures++; $display("FAIL b2b_first got=%h exp=%h", frame, e); end
        cmd_index    = 6'd23;
        cmd_argument = 32'hC0FFEE01;
        h = {2'b01, 6'd23, 32'hC0FFEE01};
        exp_q.push_back({h, crc7(h), 1'b1});
        serve(1, 0, 1'b1, sends, ns, nt, en, ls, ok);
        checks++;
        if (!ok || ns != 1) begin failures++; $display("FAIL b2b_first_sent got=%0d exp=1", ns); end
        @(negedge sd_clock);
        new_command = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept busy got=%b exp=1", busy); end
        wait_load(cyc, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cyc != 40 || frame !== e) begin
            failures++; $display("FAIL b2b_second got=%h cyc=%0d exp=%h cyc=40", frame, cyc, e);
        end
        serve(7, 0, 1'b0, sends, ns, nt, en, ls, ok);
    endtask

    task automatic test_random();
        int cyc, sends, ns, nt, en, d;
        logic ok, ls;
        logic [47:0] e;
        logic [39:0] h;
        logic [5:0]  idx;
        logic [31:0] arg;
        for (int k = 0; k < 4; k++) begin
            idx = 6'($urandom_range(0, 63));
            arg = $urandom;
            h   = {2'b01, idx, arg};
            issue(idx, arg, {h, crc7(h), 1'b1});
            wait_load(cyc, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || frame !== e) begin failures++; $display("FAIL rand_frame idx=%0d got=%h exp=%h", idx, frame, e); end
            d = $urandom_range(1, 60);
            serve(d, 0, 1'b0, sends, ns, nt, en, ls, ok);
            checks++;
            if (!ok || ns != 1 || sends != d) begin
                failures++; $display("FAIL rand_sent got sent=%0d sends=%0d exp 1/%0d", ns, sends, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_cmd17();
        test_timeout();
        test_ignore();
        test_reset_crc();
        test_reset_send();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
